// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//
// Purpose: shares a single AXI-side memory port between the I-cache miss
// fetch path and the D-cache load/store path. One access is in flight at a
// time. The granted request's fields are captured in registers and held on
// the mem_* outputs for the whole busy period. Every completion or flush
// passes through IDLE for at least one cycle before the next grant.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   undefined (default) : fixed priority, data side wins over instruction side
//   defined             : round-robin between the two sides when both request
//
// Ports:
//   aclk, aresetn      clock, synchronous active-low reset
//   i_req, i_addr      instruction fetch request and address
//   i_ready            fetch complete (mem_data valid)
//   d_req, d_write, d_size, d_sel, d_addr, d_wdata
//                      data request and its attributes
//   d_ready            data access complete
//   flush              cancels the in-flight access, blocks grants in IDLE
//   mem_access, mem_a, mem_write, mem_size, mem_sel, mem_st_data
//                      registered request to the AXI interface
//   mem_ready          completion from the AXI interface

module cache_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_sel,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic              d_ready,
    input  logic              flush,
    output logic              mem_access,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_st_data,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_access_q, mem_access_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic                mem_write_q, mem_write_d;
    logic [1:0]          mem_size_q, mem_size_d;
    logic [3:0]          mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0]   mem_st_data_q, mem_st_data_d;
    logic                grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // 0 = instruction side granted last, 1 = data side granted last
    logic                last_grant_q, last_grant_d;

    // On a tie, hand the port to whichever side did not get it last time;
    // a lone requester always wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            grant_d = ~last_grant_q;
            grant_i = last_grant_q;
        end else begin
            grant_d = d_req;
            grant_i = i_req;
        end
    end
`else
    // Fixed priority: a data request always beats an instruction fetch.
    always_comb begin
        grant_d = d_req;
        grant_i = i_req & ~d_req;
    end
`endif

    // Next-state logic. The mem_* registers double as the latched request
    // fields: loaded on a grant, held during the busy state, and cleared when
    // the access ends so that IDLE presents all-zero outputs.
    always_comb begin
        state_d       = state_q;
        mem_access_d  = mem_access_q;
        mem_a_d       = mem_a_q;
        mem_write_d   = mem_write_q;
        mem_size_d    = mem_size_q;
        mem_sel_d     = mem_sel_q;
        mem_st_data_d = mem_st_data_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d  = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                // flush in IDLE suppresses any grant this cycle
                if (!flush) begin
                    if (grant_d) begin
                        state_d       = D_BUSY;
                        mem_access_d  = 1'b1;
                        mem_a_d       = d_addr;
                        mem_write_d   = d_write;
                        mem_size_d    = d_size;
                        mem_sel_d     = d_sel;
                        mem_st_data_d = d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d  = 1'b1;
`endif
                    end else if (grant_i) begin
                        state_d       = I_BUSY;
                        mem_access_d  = 1'b1;
                        mem_a_d       = i_addr;
                        mem_write_d   = 1'b0;
                        mem_size_d    = 2'b10;
                        mem_sel_d     = 4'b1111;
                        mem_st_data_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d  = 1'b0;
`endif
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                // Completion or flush both end the access; flush wins over
                // mem_ready only in the ready outputs, the state path is shared.
                if (flush || mem_ready) begin
                    state_d       = IDLE;
                    mem_access_d  = 1'b0;
                    mem_a_d       = '0;
                    mem_write_d   = 1'b0;
                    mem_size_d    = 2'b00;
                    mem_sel_d     = 4'b0000;
                    mem_st_data_d = '0;
                end
            end
            default: begin
                state_d       = IDLE;
                mem_access_d  = 1'b0;
                mem_a_d       = '0;
                mem_write_d   = 1'b0;
                mem_size_d    = 2'b00;
                mem_sel_d     = 4'b0000;
                mem_st_data_d = '0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in progress.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            mem_access_q  <= 1'b0;
            mem_a_q       <= '0;
            mem_write_q   <= 1'b0;
            mem_size_q    <= 2'b00;
            mem_sel_q     <= 4'b0000;
            mem_st_data_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            mem_access_q  <= mem_access_d;
            mem_a_q       <= mem_a_d;
            mem_write_q   <= mem_write_d;
            mem_size_q    <= mem_size_d;
            mem_sel_q     <= mem_sel_d;
            mem_st_data_q <= mem_st_data_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    // Ready pulses pass mem_ready straight through for the busy side; they
    // are gated by flush and by reset so a cancelled access never completes.
    assign i_ready = (state_q == I_BUSY) & mem_ready & ~flush & aresetn;
    assign d_ready = (state_q == D_BUSY) & mem_ready & ~flush & aresetn;

    assign mem_access  = mem_access_q;
    assign mem_a       = mem_a_q;
    assign mem_write   = mem_write_q;
    assign mem_size    = mem_size_q;
    assign mem_sel     = mem_sel_q;
    assign mem_st_data = mem_st_data_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//
// Purpose: directed self-checking bench for cache_mem_arbiter. Each scenario
// task drives inputs just after a rising edge and compares outputs against
// hand-computed values before the next edge.
// Ports: none (top-level bench).

module tb_cache_mem_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        flush;
    logic        mem_access;
    logic [31:0] mem_a;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;

    int vectorCount = 0;
    int missCount   = 0;

    cache_mem_arbiter #(.ADDR_W(32)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ready     (i_ready),
        .d_req       (d_req),
        .d_write     (d_write),
        .d_size      (d_size),
        .d_sel       (d_sel),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .flush       (flush),
        .mem_access  (mem_access),
        .mem_a       (mem_a),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .mem_sel     (mem_sel),
        .mem_st_data (mem_st_data),
        .mem_ready   (mem_ready)
    );

    // 10 ns clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance one rising edge, then step off the edge before driving/checking.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic applyStimulus();
        i_req = 0; i_addr = '0; d_req = 0; d_write = 0; d_size = 2'b00;
        d_sel = 4'h0; d_addr = '0; d_wdata = '0; flush = 0; mem_ready = 0;
    endtask

    task automatic test_reset();
        aresetn = 0;
        applyStimulus();
        tick(); tick();
        i_req = 1; mem_ready = 1;
        #1;
        vectorCount++; if (i_ready !== 1'b0) begin $display("[TB] FAIL reset_i_ready: got %b expected 0", i_ready); missCount++; end
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL reset_access: got %b expected 0", mem_access); missCount++; end
        vectorCount++; if (mem_a !== 32'h0) begin $display("[TB] FAIL reset_addr: got %h expected 0", mem_a); missCount++; end
        vectorCount++; if (mem_sel !== 4'h0) begin $display("[TB] FAIL reset_sel: got %h expected 0", mem_sel); missCount++; end
        applyStimulus();
        aresetn = 1;
        tick();
    endtask

    // Scenario 1: lone fetch, mem_ready three cycles after the grant.
    task automatic test_lone_fetch();
        i_req = 1; i_addr = 32'hBFC00000;
        tick();
        i_addr = 32'hDEADBEEF;
        vectorCount++; if (mem_access !== 1'b1) begin $display("[TB] FAIL fetch_access: got %b expected 1", mem_access); missCount++; end
        vectorCount++; if (mem_a !== 32'hBFC00000) begin $display("[TB] FAIL fetch_addr: got %h expected bfc00000", mem_a); missCount++; end
        vectorCount++; if (mem_sel !== 4'hF) begin $display("[TB] FAIL fetch_sel: got %h expected f", mem_sel); missCount++; end
        vectorCount++; if (mem_write !== 1'b0) begin $display("[TB] FAIL fetch_write: got %b expected 0", mem_write); missCount++; end
        vectorCount++; if (mem_size !== 2'b10) begin $display("[TB] FAIL fetch_size: got %b expected 10", mem_size); missCount++; end
        vectorCount++; if (mem_st_data !== 32'h0) begin $display("[TB] FAIL fetch_wdata: got %h expected 0", mem_st_data); missCount++; end
        vectorCount++; if (i_ready !== 1'b0) begin $display("[TB] FAIL fetch_early_ready: got %b expected 0", i_ready); missCount++; end
        tick(); tick();
        vectorCount++; if (mem_a !== 32'hBFC00000) begin $display("[TB] FAIL fetch_addr_stable: got %h expected bfc00000", mem_a); missCount++; end
        tick();
        mem_ready = 1;
        #1;
        vectorCount++; if (i_ready !== 1'b1) begin $display("[TB] FAIL fetch_ready: got %b expected 1", i_ready); missCount++; end
        vectorCount++; if (d_ready !== 1'b0) begin $display("[TB] FAIL fetch_d_ready: got %b expected 0", d_ready); missCount++; end
        tick();
        i_req = 0;
        #1;
        vectorCount++; if (i_ready !== 1'b0) begin $display("[TB] FAIL fetch_ready_pulse: got %b expected 0", i_ready); missCount++; end
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL fetch_idle_access: got %b expected 0", mem_access); missCount++; end
        vectorCount++; if (mem_a !== 32'h0) begin $display("[TB] FAIL fetch_idle_addr: got %h expected 0", mem_a); missCount++; end
        mem_ready = 0;
        tick();
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL fetch_stay_idle: got %b expected 0", mem_access); missCount++; end
    endtask

`ifndef ARB_ROUND_ROBIN_EN
    // Scenario 2: both sides request together, data goes first.
    task automatic test_priority();
        i_req = 1; i_addr = 32'h00400000;
        d_req = 1; d_addr = 32'h1FAF0000; d_size = 2'b10; d_sel = 4'hF;
        tick();
        vectorCount++; if (mem_a !== 32'h1FAF0000) begin $display("[TB] FAIL prio_first_addr: got %h expected 1faf0000", mem_a); missCount++; end
        mem_ready = 1;
        #1;
        vectorCount++; if (d_ready !== 1'b1) begin $display("[TB] FAIL prio_d_ready: got %b expected 1", d_ready); missCount++; end
        vectorCount++; if (i_ready !== 1'b0) begin $display("[TB] FAIL prio_i_ready: got %b expected 0", i_ready); missCount++; end
        tick();
        d_req = 0; mem_ready = 0;
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL prio_gap: got %b expected 0", mem_access); missCount++; end
        tick();
        vectorCount++; if (mem_a !== 32'h00400000) begin $display("[TB] FAIL prio_second_addr: got %h expected 00400000", mem_a); missCount++; end
        mem_ready = 1;
        #1;
        vectorCount++; if (i_ready !== 1'b1) begin $display("[TB] FAIL prio_i_done: got %b expected 1", i_ready); missCount++; end
        tick();
        applyStimulus();
        tick();
    endtask
`else
    // Scenario 3: four back-to-back ties alternate D, I, D, I from reset.
    task automatic test_round_robin();
        logic [31:0] expAddr;
        aresetn = 0;
        tick();
        aresetn = 1;
        tick();
        i_req = 1; i_addr = 32'h00400000;
        d_req = 1; d_addr = 32'h1FAF0000; d_size = 2'b10; d_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            expAddr = (k % 2 == 0) ? 32'h1FAF0000 : 32'h00400000;
            tick();
            vectorCount++; if (mem_a !== expAddr) begin $display("[TB] FAIL rr_grant%0d: got %h expected %h", k, mem_a, expAddr); missCount++; end
            mem_ready = 1;
            tick();
            mem_ready = 0;
        end
        applyStimulus();
        tick();
    endtask
`endif

    // Scenario 4: store fields latched and held; req drop mid-access ignored.
    task automatic test_store();
        d_req = 1; d_write = 1; d_size = 2'b01; d_sel = 4'b0011;
        d_addr = 32'h80001000; d_wdata = 32'h12345678;
        tick();
        d_wdata = 32'hFFFFFFFF; d_sel = 4'hC; d_write = 0;
        vectorCount++; if (mem_write !== 1'b1) begin $display("[TB] FAIL store_write: got %b expected 1", mem_write); missCount++; end
        vectorCount++; if (mem_sel !== 4'b0011) begin $display("[TB] FAIL store_sel: got %b expected 0011", mem_sel); missCount++; end
        vectorCount++; if (mem_st_data !== 32'h12345678) begin $display("[TB] FAIL store_data: got %h expected 12345678", mem_st_data); missCount++; end
        vectorCount++; if (mem_size !== 2'b01) begin $display("[TB] FAIL store_size: got %b expected 01", mem_size); missCount++; end
        d_req = 0;
        tick(); tick();
        vectorCount++; if (mem_access !== 1'b1) begin $display("[TB] FAIL store_req_drop: got %b expected 1", mem_access); missCount++; end
        vectorCount++; if (mem_st_data !== 32'h12345678) begin $display("[TB] FAIL store_data_stable: got %h expected 12345678", mem_st_data); missCount++; end
        mem_ready = 1;
        #1;
        vectorCount++; if (d_ready !== 1'b1) begin $display("[TB] FAIL store_ready: got %b expected 1", d_ready); missCount++; end
        tick();
        applyStimulus();
        vectorCount++; if (mem_write !== 1'b0) begin $display("[TB] FAIL store_idle_write: got %b expected 0", mem_write); missCount++; end
        tick();
    endtask

    // Scenario 5 plus flush in IDLE and in I_BUSY.
    task automatic test_flush();
        d_req = 1; d_addr = 32'h00002000; d_size = 2'b10; d_sel = 4'hF;
        tick();
        flush = 1; mem_ready = 1;
        #1;
        vectorCount++; if (d_ready !== 1'b0) begin $display("[TB] FAIL flush_d_ready: got %b expected 0", d_ready); missCount++; end
        tick();
        applyStimulus();
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL flush_d_idle: got %b expected 0", mem_access); missCount++; end
        vectorCount++; if (mem_a !== 32'h0) begin $display("[TB] FAIL flush_d_addr: got %h expected 0", mem_a); missCount++; end
        flush = 1; i_req = 1; i_addr = 32'h00003000;
        tick();
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL flush_idle_block: got %b expected 0", mem_access); missCount++; end
        flush = 0;
        tick();
        vectorCount++; if (mem_a !== 32'h00003000) begin $display("[TB] FAIL flush_then_grant: got %h expected 00003000", mem_a); missCount++; end
        flush = 1;
        tick();
        applyStimulus();
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL flush_i_idle: got %b expected 0", mem_access); missCount++; end
        tick();
    endtask

    // Scenario 6: reset during I_BUSY abandons the fetch.
    task automatic test_reset_mid();
        i_req = 1; i_addr = 32'h00005000;
        tick();
        vectorCount++; if (mem_access !== 1'b1) begin $display("[TB] FAIL rstmid_busy: got %b expected 1", mem_access); missCount++; end
        aresetn = 0; mem_ready = 1;
        #1;
        vectorCount++; if (i_ready !== 1'b0) begin $display("[TB] FAIL rstmid_i_ready: got %b expected 0", i_ready); missCount++; end
        tick();
        vectorCount++; if (mem_access !== 1'b0) begin $display("[TB] FAIL rstmid_access: got %b expected 0", mem_access); missCount++; end
        vectorCount++; if (mem_a !== 32'h0) begin $display("[TB] FAIL rstmid_addr: got %h expected 0", mem_a); missCount++; end
        vectorCount++; if (mem_sel !== 4'h0 || mem_size !== 2'b00) begin $display("[TB] FAIL rstmid_ctrl: got sel=%h size=%b expected 0/00", mem_sel, mem_size); missCount++; end
        aresetn = 1;
        applyStimulus();
        tick();
    endtask

    initial begin
        $display("[TB] starting cache_mem_arbiter bench");
        test_reset();
        test_lone_fetch();
`ifndef ARB_ROUND_ROBIN_EN
        test_priority();
`else
        test_round_robin();
`endif
        test_store();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
